// File: rtl/progmem_arbiter.sv
// Round-robin arbiter sharing one single-port, 1-cycle-latency program memory
// among N_CORES fetch stages; returns read data to the granted core next cycle.
`ifndef INST_ADDR_W
`define INST_ADDR_W 16
`endif
`ifndef INST_W
`define INST_W 32
`endif

module progmem_arbiter #(
  parameter int N_CORES = 4,
  parameter int AW      = `INST_ADDR_W,
  parameter int DW      = `INST_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [N_CORES-1:0]    req,
  input  logic [N_CORES*AW-1:0] req_addr,
  input  logic [N_CORES-1:0]    cancel,
  output logic [N_CORES-1:0]    stall,
  output logic [N_CORES-1:0]    rsp_valid,
  output logic [DW-1:0]         rsp_data,
  output logic                  mem_en,
  output logic [AW-1:0]         mem_addr,
  input  logic [DW-1:0]         mem_data
);

  localparam int PW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic               pend_valid_q, pend_valid_d;
  logic [PW-1:0]      pend_id_q, pend_id_d;
  logic               pend_drop_q, pend_drop_d;

  logic               grant_found;
  logic [PW-1:0]      grant_id;
  logic [N_CORES-1:0] grant_oh;
  logic               rsp_fire;

  // Core index base+offset taken modulo N_CORES (offset never exceeds N_CORES).
  function automatic logic [PW-1:0] ring_idx(input logic [PW-1:0] base, input int offset);
    int s;
    s = int'(base) + offset;
    if (s >= N_CORES) s = s - N_CORES;
    return PW'(s);
  endfunction

  // Grant stage: first requester at or above rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = 0; k < N_CORES; k++) begin
      if (!grant_found && en && req[ring_idx(rr_ptr_q, k)]) begin
        grant_found = 1'b1;
        grant_id    = ring_idx(rr_ptr_q, k);
      end
    end
    grant_oh = grant_found ? (N_CORES'(1) << grant_id) : '0;
  end

  always_comb begin
    mem_addr = '0;
    for (int i = 0; i < N_CORES; i++) begin
      if (grant_oh[i]) mem_addr = req_addr[i*AW +: AW];
    end
  end

  assign mem_en = grant_found;
  assign stall  = req & ~grant_oh;

  always_comb begin
    rr_ptr_d     = grant_found ? ring_idx(grant_id, 1) : rr_ptr_q;
    pend_valid_d = grant_found;
    pend_id_d    = grant_found ? grant_id : pend_id_q;
    // A flush raised while the read is being issued kills it just like a later one.
    pend_drop_d  = grant_found & cancel[grant_id];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= '0;
      pend_valid_q <= 1'b0;
      pend_id_q    <= '0;
      pend_drop_q  <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      pend_valid_q <= pend_valid_d;
      pend_id_q    <= pend_id_d;
      pend_drop_q  <= pend_drop_d;
    end
  end

  // Response stage: memory data passes straight through to the owning core.
  assign rsp_fire  = pend_valid_q & ~pend_drop_q & ~cancel[pend_id_q];
  assign rsp_valid = rsp_fire ? (N_CORES'(1) << pend_id_q) : '0;
  assign rsp_data  = rsp_fire ? mem_data : '0;

endmodule

// File: tb/tb_progmem_arbiter.sv
// Randomized bench for progmem_arbiter against a queue-free round-robin model,
// plus directed scenarios with literal expectations.
module tb_progmem_arbiter;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic [N-1:0]    req;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    cancel;
  logic [N-1:0]    stall;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            mem_en;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_data;

  progmem_arbiter #(.N_CORES(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .req_addr(req_addr),
    .cancel(cancel), .stall(stall), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [256];
  int checks = 0;
  int errors = 0;

  // Model state: next core to favour, and the read (if any) now in memory.
  int          m_rr;
  bit          m_pend;
  int          m_pid;
  bit          m_pdrop;
  logic [AW-1:0] m_last_addr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_grant();
    int c;
    if (!en) return -1;
    for (int k = 0; k < N; k++) begin
      c = (m_rr + k) % N;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_check();
    int g;
    logic [N-1:0]  exp_stall;
    logic [AW-1:0] exp_addr;
    logic [N-1:0]  exp_rv;
    logic [DW-1:0] exp_rd;
    g = model_grant();
    exp_stall = req;
    exp_addr  = '0;
    if (g >= 0) begin
      exp_stall[g] = 1'b0;
      exp_addr = req_addr[g*AW +: AW];
    end
    exp_rv = '0;
    exp_rd = '0;
    if (rst_n && m_pend && !m_pdrop && !cancel[m_pid]) begin
      exp_rv[m_pid] = 1'b1;
      exp_rd = mem_data;
    end
    check("mem_en", mem_en, (g >= 0));
    check("mem_addr", mem_addr, exp_addr);
    check("stall", stall, exp_stall);
    check("rsp_valid", rsp_valid, exp_rv);
    check("rsp_data", rsp_data, exp_rd);
  endtask

  task automatic model_reset();
    m_rr = 0; m_pend = 0; m_pid = 0; m_pdrop = 0;
  endtask

  // Clock edge, model update from the inputs the DUT sampled, then memory reply.
  task automatic advance();
    int g;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      g = model_grant();
      m_pend  = (g >= 0);
      m_pdrop = (g >= 0) && cancel[g];
      if (g >= 0) begin
        m_pid = g;
        m_rr = (g + 1) % N;
        m_last_addr = req_addr[g*AW +: AW];
      end
    end
    @(negedge clk);
    mem_data = m_pend ? mem[m_last_addr] : DW'($urandom);
  endtask

  task automatic drive(input logic [N-1:0] r, input logic [N-1:0] c, input logic e);
    req = r; cancel = c; en = e;
  endtask

  task automatic settle_check();
    #1;
    model_check();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[5] = 32'hDEAD;
    model_reset();
    m_last_addr = '0;
    rst_n = 1'b0;
    drive('0, '0, 1'b1);
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'(8'h10 * i + 3);
    mem_data = '0;
    #1;
    check("reset rsp_valid", rsp_valid, 4'b0000);
    check("reset rsp_data", rsp_data, 32'h0);
    check("reset mem_en", mem_en, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // All cores requesting from reset: strict 0,1,2,3 rotation.
    drive(4'b1111, '0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      #1;
      check("rot stall", stall, 4'b1111 & ~(4'b0001 << (i % 4)));
      check("rot mem_addr", mem_addr, AW'(8'h10 * (i % 4) + 3));
      if (i >= 1) check("rot rsp_valid", rsp_valid, 4'b0001 << ((i - 1) % 4));
      model_check();
      advance();
    end

    // Single requester, address 5 -> 0xDEAD.
    req_addr[0*AW +: AW] = AW'(5);
    drive(4'b0001, '0, 1'b1);
    #1;
    check("single mem_en", mem_en, 1'b1);
    check("single mem_addr", mem_addr, 8'h05);
    check("single stall", stall, 4'b0000);
    model_check();
    advance();
    drive(4'b0000, '0, 1'b1);
    #1;
    check("single rsp_valid", rsp_valid, 4'b0001);
    check("single rsp_data", rsp_data, 32'hDEAD);
    model_check();
    advance();

    // rr_ptr=2 then req=1001: core 3 first, then core 0, pointer left at 1.
    drive(4'b0010, '0, 1'b1); settle_check(); advance();
    drive(4'b1001, '0, 1'b1);
    #1;
    check("wrap stall 3", stall, 4'b0001);
    check("wrap addr 3", mem_addr, req_addr[3*AW +: AW]);
    model_check();
    advance();
    drive(4'b0001, '0, 1'b1);
    #1;
    check("wrap stall 0", stall, 4'b0000);
    check("wrap rsp 3", rsp_valid, 4'b1000);
    model_check();
    advance();
    drive(4'b0011, '0, 1'b1);
    #1;
    check("wrap ptr 1", stall, 4'b0001);
    model_check();
    advance();

    // Cancel in response cycle drops the reply; the next grant proceeds.
    drive(4'b0010, '0, 1'b1); settle_check(); advance();
    drive(4'b0000, 4'b0010, 1'b1);
    #1;
    check("cancel rsp_valid", rsp_valid, 4'b0000);
    check("cancel rsp_data", rsp_data, 32'h0);
    model_check();
    advance();
    drive(4'b0100, '0, 1'b1); settle_check(); advance();
    drive(4'b0000, '0, 1'b1);
    #1;
    check("after cancel rsp", rsp_valid, 4'b0100);
    model_check();
    advance();

    // Cancel in grant cycle: still granted, reply suppressed.
    drive(4'b0001, 4'b0001, 1'b1);
    #1;
    check("gcancel mem_en", mem_en, 1'b1);
    check("gcancel stall", stall, 4'b0000);
    model_check();
    advance();
    drive(4'b0000, '0, 1'b1);
    #1;
    check("gcancel rsp", rsp_valid, 4'b0000);
    model_check();
    advance();

    // en dropped after a grant to core 2: reply still delivered.
    drive(4'b0100, '0, 1'b1); settle_check(); advance();
    drive(4'b0101, '0, 1'b0);
    #1;
    check("en rsp_valid", rsp_valid, 4'b0100);
    check("en mem_en", mem_en, 1'b0);
    check("en stall", stall, 4'b0101);
    model_check();
    advance();
    #1;
    check("en idle rsp", rsp_valid, 4'b0000);
    check("en idle stall", stall, 4'b0101);
    model_check();
    advance();

    // Reset during a response cycle discards the in-flight read.
    drive(4'b0010, '0, 1'b1); settle_check(); advance();
    drive(4'b0000, '0, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst rsp_valid", rsp_valid, 4'b0000);
    model_reset();
    model_check();
    advance();
    rst_n = 1'b1;
    drive(4'b1111, '0, 1'b1);
    #1;
    check("rst rr_ptr", stall, 4'b1110);
    check("rst rsp after", rsp_valid, 4'b0000);
    model_check();
    advance();

    // Randomized traffic.
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'($urandom);
      drive(N'($urandom), ($urandom_range(0, 7) == 0) ? N'($urandom) : '0,
            $urandom_range(0, 7) != 0);
      settle_check();
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/progmem_arbiter.md
PROGMEM_ARBITER -- requirements
Module: progmem_arbiter

Interface
REQ-001 Parameter N_CORES, default 4: number of fetch requesters; legal range 2..8.
REQ-002 Parameter AW, default `INST_ADDR_W: instruction address width.
REQ-003 Parameter DW, default `INST_W: instruction width.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 en  in  1  global enable; when low, no new grants are issued.
REQ-007 req  in  N_CORES  per-core fetch request, level, held until granted.
REQ-008 req_addr  in  N_CORES*AW  per-core fetch address; core i occupies bits [i*AW +: AW].
REQ-009 cancel  in  N_CORES  per-core flush; discards that core's in-flight response.
REQ-010 stall  out  N_CORES  per-core stall: request pending but not granted this cycle.
REQ-011 rsp_valid  out  N_CORES  one-hot pulse: instruction for core i is on rsp_data.
REQ-012 rsp_data  out  DW  instruction returned to the core flagged in rsp_valid.
REQ-013 mem_en  out  1  program-memory read strobe.
REQ-014 mem_addr  out  AW  program-memory read address.
REQ-015 mem_data  in  DW  program-memory read data, valid exactly one cycle after mem_en.

Function
REQ-016 The block shall share one single-port, 1-cycle-latency program memory among N_CORES fetch stages, issuing at most one read per cycle.
REQ-017 Grant (combinational) shall be the first core with req=1, searching upward from rr_ptr with wrap-around N_CORES-1 -> 0; with en=0 or no request, no grant.
REQ-018 mem_en shall equal (grant exists); mem_addr shall equal req_addr of the granted core, else all zeros.
REQ-019 stall[i] shall equal req[i] AND NOT grant[i], combinational, same cycle.
REQ-020 On a grant to core g, rr_ptr shall update to (g+1) mod N_CORES at the next edge; with no grant, rr_ptr shall hold.
REQ-021 On a grant, the block shall register pend_valid=1 and pend_id=g; with no grant, pend_valid=0.
REQ-022 In the cycle after a grant, rsp_valid[pend_id] shall be 1 and rsp_data shall equal mem_data (1-cycle latency, pass-through), unless suppressed per REQ-023.
REQ-023 If cancel[pend_id]=1 in the response cycle, or cancel[g]=1 in the grant cycle, that response shall be suppressed: rsp_valid stays all zeros.
REQ-024 rsp_data shall be all zeros whenever rsp_valid is all zeros.
REQ-025 Back-to-back grants shall be supported: grant in cycle t+1 and response for grant t occur in the same cycle.
REQ-026 A single requester shall be granted every cycle (full throughput); with all N_CORES requesting, each core shall be granted exactly once every N_CORES cycles.
REQ-027 Deassertion of en while a read is in flight shall not drop its response.
REQ-028 cancel shall not affect grant selection or rr_ptr; a core asserting req and cancel together is still granted.

Reset
REQ-029 While rst_n=0: rr_ptr=0, pend_valid=0, pend_id=0, all regardless of clk.
REQ-030 Output values during and immediately after reset: rsp_valid=0, rsp_data=0; mem_en, mem_addr and stall follow REQ-017..019 from current inputs.
REQ-031 A read in flight when rst_n falls shall be discarded; no rsp_valid shall follow reset release.

Verification
REQ-032 Single requester: req=0001, req_addr[0]=0x05, mem returns 0xDEAD -> mem_en=1, mem_addr=0x05, stall=0000; next cycle rsp_valid=0001, rsp_data=0xDEAD.
REQ-033 All four request continuously from reset -> grant order 0,1,2,3,0,...; stall shows exactly three bits set each cycle; rsp_valid is one-hot every cycle from cycle 2 onward.
REQ-034 rr_ptr=2, req=1001 -> core 3 granted first, then core 0; rr_ptr ends at 1.
REQ-035 Core 1 granted, cancel[1]=1 in the following cycle -> rsp_valid=0000, rsp_data=0; the next grant proceeds normally.
REQ-036 en dropped the cycle after a grant to core 2 -> rsp_valid=0100 delivered; mem_en=0 and stall=req thereafter.
REQ-037 rst_n pulsed low during the response cycle of an in-flight read -> rsp_valid=0000 immediately and after release; rr_ptr=0.
